// File: rtl/run_length_logger_pkg.sv
// Shared types and constants for the run-length logger.
package run_log_pkg;

    // Shortest run the detector flags; length loaded on det_y rise.
    localparam int unsigned RUN_MIN_LEN = 3;
    localparam int unsigned DEF_LEN_W   = 8;

    typedef enum logic {
        IDLE,
        RUN
    } run_state_e;

    // Record at the default length width; the top declares its own copy sized by LEN_W.
    typedef struct packed {
        logic                 pol;
        logic                 sat;
        logic [DEF_LEN_W-1:0] len;
    } run_rec_t;

    // Packed record width: polarity + saturation + length field.
    function automatic int unsigned rec_width(input int unsigned len_w);
        return len_w + 2;
    endfunction

endpackage

// File: rtl/run_length_logger_if.sv
// Record read-out channel: valid/ready plus the head record fields.
interface run_length_logger_if #(
    parameter int unsigned LEN_W = 8
);
    logic             rec_valid;
    logic             rec_ready;
    logic             rec_pol;
    logic             rec_sat;
    logic [LEN_W-1:0] rec_len;

    modport master (
        output rec_valid,
        output rec_pol,
        output rec_sat,
        output rec_len,
        input  rec_ready
    );

    modport slave (
        input  rec_valid,
        input  rec_pol,
        input  rec_sat,
        input  rec_len,
        output rec_ready
    );
endinterface

// File: rtl/run_length_logger_rec_fifo.sv
// Record FIFO: synchronous reset, no bypass, accepts a push on full when a pop happens
// in the same cycle. Head reads as zero while empty.
module rec_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    output logic                    valid,
    output logic [WIDTH-1:0]        head,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    drop
);
    localparam int unsigned    PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign valid   = (count_q != '0);
    assign full    = (count_q == FULL_CNT);
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;
    assign head    = valid ? mem_q[rd_ptr_q] : '0;
    assign count   = count_q;

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/run_length_logger.sv
// Measures each run flagged by the serial run detector and queues one
// {polarity, length, saturated} record per completed run for a valid/ready reader.
module run_length_logger
    import run_log_pkg::*;
#(
    parameter int unsigned LEN_W = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   x,
    input  logic                   det_y,
    run_length_logger_if.master    rec,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow,
    output logic [CNT_W-1:0]       drop_cnt
);
    localparam int unsigned      REC_W   = rec_width(LEN_W);
    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    typedef struct packed {
        logic             pol;
        logic             sat;
        logic [LEN_W-1:0] len;
    } rec_t;

    run_state_e       state_q;
    logic             prev_x_q;
    logic             pol_q;
    logic             sat_q;
    logic [LEN_W-1:0] len_q;
    logic             overflow_q;
    logic [CNT_W-1:0] drop_cnt_q;

    logic             push;
    logic             drop;
    logic             head_valid;
    logic [REC_W-1:0] head_bits;
    rec_t             push_rec;
    rec_t             head_rec;

    // A run ends on the first low det_y cycle; its record is pushed in that same cycle.
    assign push     = (state_q == RUN) && !det_y;
    assign push_rec = '{pol: pol_q, sat: sat_q, len: len_q};
    assign head_rec = head_bits;

    // Run tracker: det_y rises one cycle after the third equal bit, so the run
    // polarity is the previous bit and the length starts at the minimum run.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            prev_x_q <= 1'b0;
            pol_q    <= 1'b0;
            sat_q    <= 1'b0;
            len_q    <= '0;
        end else begin
            prev_x_q <= x;
            unique case (state_q)
                IDLE: begin
                    if (det_y) begin
                        state_q <= RUN;
                        pol_q   <= prev_x_q;
                        sat_q   <= 1'b0;
                        len_q   <= LEN_W'(RUN_MIN_LEN);
                    end
                end
                RUN: begin
                    if (det_y) begin
                        if (len_q == LEN_MAX) begin
                            sat_q <= 1'b1;
                        end else begin
                            len_q <= len_q + 1'b1;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Sticky overflow flag and saturating count of records lost to a full FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (drop_cnt_q != '1) begin
                drop_cnt_q <= drop_cnt_q + 1'b1;
            end
        end
    end

    rec_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_rec),
        .pop       (rec.rec_ready),
        .valid     (head_valid),
        .head      (head_bits),
        .count     (fifo_count),
        .drop      (drop)
    );

    assign rec.rec_valid = head_valid;
    assign rec.rec_pol   = head_rec.pol;
    assign rec.rec_sat   = head_rec.sat;
    assign rec.rec_len   = head_rec.len;
    assign overflow      = overflow_q;
    assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_run_length_logger.sv
// Bench for run_length_logger: two instances (LEN_W=8 and LEN_W=4) share one stimulus
// stream; a queue-based model of the record stream is checked every cycle.
module tb_run_length_logger;

    logic       clk = 1'b0;
    logic       reset;
    logic       x;
    logic       det_y;
    logic       ready;
    logic [2:0] cnt8, cnt4;
    logic       ovf8, ovf4;
    logic [7:0] dc8, dc4;

    run_length_logger_if #(.LEN_W(8)) bus8 ();
    run_length_logger_if #(.LEN_W(4)) bus4 ();

    assign bus8.rec_ready = ready;
    assign bus4.rec_ready = ready;

    run_length_logger #(.LEN_W(8), .DEPTH(4), .CNT_W(8)) dut8 (
        .clk        (clk),
        .reset      (reset),
        .x          (x),
        .det_y      (det_y),
        .rec        (bus8.master),
        .fifo_count (cnt8),
        .overflow   (ovf8),
        .drop_cnt   (dc8)
    );

    run_length_logger #(.LEN_W(4), .DEPTH(4), .CNT_W(8)) dut4 (
        .clk        (clk),
        .reset      (reset),
        .x          (x),
        .det_y      (det_y),
        .rec        (bus4.master),
        .fifo_count (cnt4),
        .overflow   (ovf4),
        .drop_cnt   (dc4)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Reference model: a list of completed runs per instance width.
    typedef struct {
        logic        pol;
        int unsigned len;
        logic        sat;
    } mrec_t;

    mrec_t       mq[2][$];
    int unsigned md[2];
    bit          mov[2];
    bit          m_in_run;
    int unsigned m_highs;
    logic        m_pol;
    logic        m_prev_x;

    // Bench-side serial run detector.
    int   det_run;
    logic det_last;

    function automatic int unsigned mwidth(input int i);
        return (i == 0) ? 8 : 4;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one clock edge's worth of the run/record rules to the model.
    task automatic model_edge(input logic r, input logic xb, input logic d, input logic rdy);
        if (r) begin
            for (int i = 0; i < 2; i++) begin
                mq[i].delete();
                md[i]  = 0;
                mov[i] = 1'b0;
            end
            m_in_run = 1'b0;
            m_highs  = 0;
            m_pol    = 1'b0;
            m_prev_x = 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                int unsigned maxv;
                int unsigned total;
                mrec_t       nr;
                if (mq[i].size() > 0 && rdy) begin
                    void'(mq[i].pop_front());
                end
                if (m_in_run && !d) begin
                    maxv   = (1 << mwidth(i)) - 1;
                    total  = m_highs + 2;
                    nr.pol = m_pol;
                    nr.len = (total > maxv) ? maxv : total;
                    nr.sat = (total > maxv);
                    if (mq[i].size() < 4) begin
                        mq[i].push_back(nr);
                    end else begin
                        mov[i] = 1'b1;
                        md[i]  = (md[i] == 255) ? 255 : md[i] + 1;
                    end
                end
            end
            if (d && !m_in_run) begin
                m_in_run = 1'b1;
                m_pol    = m_prev_x;
                m_highs  = 1;
            end else if (d) begin
                m_highs++;
            end else begin
                m_in_run = 1'b0;
            end
            m_prev_x = xb;
        end
    endtask

    task automatic step(input logic r, input logic xb, input logic d, input logic rdy);
        reset = r;
        x     = xb;
        det_y = d;
        ready = rdy;
        @(posedge clk);
        #2;
        model_edge(r, xb, d, rdy);
    endtask

    task automatic step_rst(input logic xb);
        step(1'b1, xb, 1'b0, 1'b0);
        det_run  = 0;
        det_last = 1'b0;
    endtask

    // Feed one serial bit; det_y follows the detector rule (run of >=3 so far).
    task automatic step_x(input logic xb, input logic rdy);
        logic d;
        d = (det_run >= 3);
        step(1'b0, xb, d, rdy);
        if (xb == det_last) det_run++;
        else det_run = 1;
        det_last = xb;
    endtask

    // Alternating bit: never extends a run.
    task automatic step_alt(input logic rdy);
        step_x(~det_last, rdy);
    endtask

    // n consecutive runs of length 3, closed off; optional ready on the last push.
    task automatic run_triples(input int n, input logic rdy_last);
        logic b;
        b = ~det_last;
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < 3; j++) step_x(b, 1'b0);
            b = ~b;
        end
        step_x(b, 1'b0);
        step_x(~b, rdy_last);
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            mrec_t       h;
            logic        ev;
            logic [31:0] av, ap, al, as, ac, ao, ad;
            string       pre;
            ev = (mq[i].size() > 0);
            if (ev) h = mq[i][0];
            else h = '{pol: 1'b0, len: 0, sat: 1'b0};
            if (i == 0) begin
                pre = "w8";
                av = 32'(bus8.rec_valid); ap = 32'(bus8.rec_pol); al = 32'(bus8.rec_len);
                as = 32'(bus8.rec_sat);   ac = 32'(cnt8);         ao = 32'(ovf8);
                ad = 32'(dc8);
            end else begin
                pre = "w4";
                av = 32'(bus4.rec_valid); ap = 32'(bus4.rec_pol); al = 32'(bus4.rec_len);
                as = 32'(bus4.rec_sat);   ac = 32'(cnt4);         ao = 32'(ovf4);
                ad = 32'(dc4);
            end
            check({pre, " rec_valid"},  av, 32'(ev));
            check({pre, " rec_pol"},    ap, 32'(h.pol));
            check({pre, " rec_len"},    al, h.len);
            check({pre, " rec_sat"},    as, 32'(h.sat));
            check({pre, " fifo_count"}, ac, mq[i].size());
            check({pre, " overflow"},   ao, 32'(mov[i]));
            check({pre, " drop_cnt"},   ad, md[i]);
        end
    endtask

    // Per-cycle comparison, mid-cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) compare_all();
        end
    end

    initial begin
        logic exp_pol [4];
        exp_pol[0] = 1'b1; exp_pol[1] = 1'b0; exp_pol[2] = 1'b1; exp_pol[3] = 1'b0;
        det_run  = 0;
        det_last = 1'b0;

        // Reset
        step_rst(1'b0);
        chk_en = 1'b1;
        step_rst(1'b0);
        check("reset rec_valid", 32'(bus8.rec_valid), 0);
        check("reset fifo_count", 32'(cnt8), 0);
        check("reset overflow", 32'(ovf8), 0);

        // 1,1,1,0,0 -> pol=1 len=3, visible the cycle after det_y falls
        for (int k = 0; k < 3; k++) step_x(1'b1, 1'b0);
        step_x(1'b0, 1'b0);
        check("t1 no valid while det_y high", 32'(bus8.rec_valid), 0);
        step_x(1'b0, 1'b0);
        check("t1 rec_valid", 32'(bus8.rec_valid), 1);
        check("t1 rec_pol", 32'(bus8.rec_pol), 1);
        check("t1 rec_len", 32'(bus8.rec_len), 3);
        check("t1 rec_sat", 32'(bus8.rec_sat), 0);

        // Ten zeros then ones -> pol=0 len=10
        for (int k = 0; k < 8; k++) step_x(1'b0, 1'b1);
        step_x(1'b1, 1'b1);
        step_x(1'b1, 1'b0);
        check("t2 rec_pol", 32'(bus8.rec_pol), 0);
        check("t2 rec_len", 32'(bus8.rec_len), 10);
        check("t2 w4 rec_len", 32'(bus4.rec_len), 10);
        check("t2 w4 rec_sat", 32'(bus4.rec_sat), 0);

        // Twenty ones: LEN_W=8 gives 20, LEN_W=4 saturates at 15
        for (int k = 0; k < 18; k++) step_x(1'b1, 1'b1);
        step_x(1'b0, 1'b1);
        step_x(1'b0, 1'b0);
        check("t3 w8 rec_len", 32'(bus8.rec_len), 20);
        check("t3 w8 rec_sat", 32'(bus8.rec_sat), 0);
        check("t3 w4 rec_pol", 32'(bus4.rec_pol), 1);
        check("t3 w4 rec_len", 32'(bus4.rec_len), 15);
        check("t3 w4 rec_sat", 32'(bus4.rec_sat), 1);

        // Six runs into a 4-deep FIFO with no reader
        step_rst(1'b0);
        run_triples(6, 1'b0);
        check("t4 fifo_count", 32'(cnt8), 4);
        check("t4 overflow", 32'(ovf8), 1);
        check("t4 drop_cnt", 32'(dc8), 2);
        check("t4 w4 drop_cnt", 32'(dc4), 2);
        for (int k = 0; k < 4; k++) begin
            check("t4 drain rec_pol", 32'(bus8.rec_pol), 32'(exp_pol[k]));
            check("t4 drain rec_len", 32'(bus8.rec_len), 3);
            step_alt(1'b1);
        end
        check("t4 drained", 32'(cnt8), 0);

        // Full FIFO, reader accepts in the push cycle: push kept, no drop
        run_triples(5, 1'b1);
        check("t5 fifo_count", 32'(cnt8), 4);
        check("t5 drop_cnt", 32'(dc8), 2);
        for (int k = 0; k < 5; k++) step_alt(1'b1);

        // Reset in the middle of a seven-bit ones run
        step_x(1'b0, 1'b0);
        for (int k = 0; k < 4; k++) step_x(1'b1, 1'b0);
        step_rst(1'b1);
        check("t6 reset rec_valid", 32'(bus8.rec_valid), 0);
        check("t6 reset overflow", 32'(ovf8), 0);
        check("t6 reset drop_cnt", 32'(dc8), 0);
        step_x(1'b1, 1'b0);
        step_x(1'b1, 1'b0);
        for (int k = 0; k < 4; k++) step_alt(1'b0);
        check("t6 no record", 32'(cnt8), 0);

        // det_y low for a single cycle between two runs
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("t7 fifo_count", 32'(cnt8), 2);
        check("t7 first rec_len", 32'(bus8.rec_len), 4);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("t7 second rec_len", 32'(bus8.rec_len), 5);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
